simple_axi_master_arbiter: RTL

//  Round-robin arbiter sharing one simple_axi_master command port between NREQ requesters.

---
 rtl/simple_axi_arb_pkg.sv | 29 ++
 rtl/rr_pick.sv | 28 ++
 rtl/simple_axi_master_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/simple_axi_arb_pkg.sv
// Shared constants and types for the simple_axi_master round-robin arbiter.
// The optional feature ARB_FIXED_PRIO0_EN is handled in simple_axi_master_arbiter.
package simple_axi_arb_pkg;

    // Requester / master rw encodings. RW_RSVD is never granted.
    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;
    localparam logic [1:0] RW_READ  = 2'b10;
    localparam logic [1:0] RW_RSVD  = 2'b11;

    // Transfer size encodings, passed through unchanged to the master.
    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HALF  = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [2:0] SIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        CLEAR = 2'd3
    } arb_state_t;

    // A requester competes only with a real read or write; idle and reserved do not.
    function automatic logic rw_eligible(input logic [1:0] rw);
        return (rw == RW_WRITE) || (rw == RW_READ);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after i_ptr,
// wrapping modulo NREQ. Any priority masking is applied by the caller.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_mask,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from farthest to nearest so the nearest candidate is the final write.
    always_comb begin
        int cand;
        cand    = 0;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(i_ptr) + k) % NREQ;
            if (i_mask[cand]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/simple_axi_master_arbiter.sv
// Round-robin arbiter sharing one simple_axi_master command port among NREQ
// requesters. FSM: IDLE -> ISSUE -> BUSY -> CLEAR -> IDLE.
// Handshake: a requester holds i_req_rw (01 write / 10 read) until o_ack pulses
// for one cycle; o_rdata/o_error/o_invalid are valid on that cycle.
// Build option: define ARB_FIXED_PRIO0_EN to give requester 0 absolute
// priority while the others rotate round-robin among themselves.
module simple_axi_master_arbiter
    import simple_axi_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [2*NREQ-1:0]    i_req_rw,
    input  logic [3*NREQ-1:0]    i_req_size,
    input  logic [32*NREQ-1:0]   i_req_addr,
    input  logic [64*NREQ-1:0]   i_req_wdata,
    output logic [NREQ-1:0]      o_ack,
    output logic [63:0]          o_rdata,
    output logic                 o_error,
    output logic                 o_invalid,
    output logic [IDX_W-1:0]     o_grant_idx,
    output logic                 o_busy,
    output logic [2:0]           m_size,
    output logic [31:0]          m_addr,
    output logic [63:0]          m_wdata,
    output logic [1:0]           m_rw,
    output logic                 m_clear,
    input  logic [63:0]          m_rdata,
    input  logic                 m_wait,
    input  logic                 m_done,
    input  logic                 m_error,
    input  logic                 m_invalid
);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [1:0]        cmd_rw_q, cmd_rw_d;
    logic [2:0]        cmd_size_q, cmd_size_d;
    logic [31:0]       cmd_addr_q, cmd_addr_d;
    logic [63:0]       cmd_wdata_q, cmd_wdata_d;
    logic [63:0]       rdata_q, rdata_d;
    logic              error_q, error_d;
    logic              invalid_q, invalid_d;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   pick_mask;
    logic              rr_valid;
    logic [IDX_W-1:0]  rr_idx;
    logic              sel_valid;
    logic [IDX_W-1:0]  sel_idx;
    logic [1:0]        sel_rw;
    logic [2:0]        sel_size;
    logic [31:0]       sel_addr;
    logic [63:0]       sel_wdata;
    logic              m_status;
    logic [IDX_W-1:0]  grant_next;

    // Any completion status still showing from the master blocks a new start.
    assign m_status   = m_done | m_error | m_invalid;
    assign grant_next = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;

    // Decode which requesters are asking for a real transfer.
    always_comb begin
        eligible = '0;
        for (int k = 0; k < NREQ; k++) begin
            eligible[k] = rw_eligible(i_req_rw[2*k +: 2]);
        end
    end

`ifdef ARB_FIXED_PRIO0_EN
    // Requester 0 is taken out of the rotation; it wins outright when eligible.
    always_comb begin
        pick_mask    = eligible;
        pick_mask[0] = 1'b0;
    end
`else
    assign pick_mask = eligible;
`endif

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_mask  (pick_mask),
        .i_ptr   (rr_ptr_q),
        .o_valid (rr_valid),
        .o_idx   (rr_idx)
    );

    // Final winner: round-robin result, overridden by requester 0 when prioritised.
    always_comb begin
        sel_valid = rr_valid;
        sel_idx   = rr_idx;
`ifdef ARB_FIXED_PRIO0_EN
        if (eligible[0]) begin
            sel_valid = 1'b1;
            sel_idx   = '0;
        end
`endif
    end

    // Mux the winning requester's command fields.
    always_comb begin
        sel_rw    = RW_IDLE;
        sel_size  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                sel_rw    = i_req_rw[2*k +: 2];
                sel_size  = i_req_size[3*k +: 3];
                sel_addr  = i_req_addr[32*k +: 32];
                sel_wdata = i_req_wdata[64*k +: 64];
            end
        end
    end

    // Next-state and register updates for the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cmd_rw_d    = cmd_rw_q;
        cmd_size_d  = cmd_size_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        invalid_d   = invalid_q;
        case (state_q)
            IDLE: begin
                if (sel_valid && !m_status) begin
                    grant_d     = sel_idx;
                    cmd_rw_d    = sel_rw;
                    cmd_size_d  = sel_size;
                    cmd_addr_d  = sel_addr;
                    cmd_wdata_d = sel_wdata;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (m_wait || m_status) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (m_status) begin
                    rdata_d   = m_rdata;
                    error_d   = m_error;
                    invalid_d = m_invalid;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                state_d = IDLE;
`ifdef ARB_FIXED_PRIO0_EN
                if (grant_q != '0) begin
                    rr_ptr_d = grant_next;
                end
`else
                rr_ptr_d = grant_next;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; asynchronous reset returns everything to idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cmd_rw_q    <= RW_IDLE;
            cmd_size_q  <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cmd_rw_q    <= cmd_rw_d;
            cmd_size_q  <= cmd_size_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            invalid_q   <= invalid_d;
        end
    end

    // The master sees a command only during ISSUE; CLEAR acks and clears status.
    assign m_rw        = (state_q == ISSUE) ? cmd_rw_q : RW_IDLE;
    assign m_size      = cmd_size_q;
    assign m_addr      = cmd_addr_q;
    assign m_wdata     = cmd_wdata_q;
    assign m_clear     = (state_q == CLEAR);
    assign o_ack       = (state_q == CLEAR) ? (NREQ'(1) << grant_q) : '0;
    assign o_rdata     = rdata_q;
    assign o_error     = error_q;
    assign o_invalid   = invalid_q;
    assign o_grant_idx = grant_q;
    assign o_busy      = (state_q != IDLE);

endmodule
